// File: rtl/fmcw_pkg.sv
// fmcw_pkg: shared widths, constants and saturation
// helper for the FMCW windowing datapath.
package fmcw_pkg;

  localparam int N_SAMPLES     = 128;
  localparam int SAMPLE_W      = 16;
  localparam int COEF_W        = 16;
  localparam int OUT_W         = 16;
  localparam int FIFO_DEPTH    = 4;
  localparam int COEF_DATA_LAG = 1;

  localparam int PROD_W = SAMPLE_W + COEF_W + 1;
  localparam int IDX_W  = $clog2(N_SAMPLES);
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

  localparam logic signed [PROD_W-1:0] ROUND_C =
    PROD_W'(1 << (COEF_W - 1));
  localparam logic signed [PROD_W-1:0] OUT_MAX =
    PROD_W'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [PROD_W-1:0] OUT_MIN =
    -OUT_MAX - PROD_W'(1);

  typedef struct packed {
    logic              vld;
    logic              last;
    logic [PROD_W-1:0] prod;
  } s1_t;

  function automatic logic [OUT_W-1:0] sat_signed(
    input logic signed [PROD_W-1:0] v
  );
    logic [OUT_W-1:0] r;
    if (v > OUT_MAX)
      r = {1'b0, {(OUT_W-1){1'b1}}};
    else if (v < OUT_MIN)
      r = {1'b1, {(OUT_W-1){1'b0}}};
    else
      r = v[OUT_W-1:0];
    return r;
  endfunction

endpackage

// File: rtl/coef_fifo.sv
// coef_fifo: small synchronous FIFO holding Hann
// coefficients until their sample arrives.
module coef_fifo #(
  parameter int DW    = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic [DW-1:0]              wdata_i,
  input  logic                       pop_i,
  output logic [DW-1:0]              rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          wr_en, rd_en;

  assign full_o  = count_q == (AW+1)'(DEPTH);
  assign empty_o = count_q == '0;
  assign rd_en   = pop_i && !empty_o;
  assign wr_en   = push_i && (!full_o || rd_en);
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q + AW'(wr_en);
    rd_ptr_d = rd_ptr_q + AW'(rd_en);
    count_d  = count_q + (AW+1)'(wr_en)
             - (AW+1)'(rd_en);
    if (wr_en) mem_d[wr_ptr_q] = wdata_i;
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/hann_window_apply.sv
// hann_window_apply: multiplies ADC samples by Hann
// coefficients and frames them for the range FFT.
module hann_window_apply
  import fmcw_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                s_sample_tvalid,
  output logic                s_sample_tready,
  input  logic [SAMPLE_W-1:0] s_sample_tdata,
  output logic                coef_enable,
  input  logic                coef_tvalid,
  input  logic [COEF_W-1:0]   coef_tdata,
  output logic                m_axis_tvalid,
  input  logic                m_axis_tready,
  output logic [OUT_W-1:0]    m_axis_tdata,
  output logic                m_axis_tlast,
  output logic                frame_done,
  output logic                coef_overflow
);

  logic [COEF_DATA_LAG-1:0] lag_q, lag_d;
  logic [CNT_W-1:0]         inf_q, inf_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic                     en_q, en_d;
  logic                     ovf_q, ovf_d;
  logic                     fd_q, fd_d;
  s1_t                      s1_q, s1_d;
  logic                     mv_q, mv_d;
  logic                     ml_q, ml_d;
  logic [OUT_W-1:0]         md_q, md_d;

  logic [CNT_W:0]           occ_nxt;
  logic signed [PROD_W-1:0] rnd;
  logic [COEF_W-1:0]        fifo_rdata;
  logic [CNT_W-1:0]         fifo_cnt;
  logic                     fifo_full, fifo_empty;
  logic                     coef_push, push_ok;
  logic                     advance, hs;

  assign coef_push = lag_q[COEF_DATA_LAG-1];
  assign advance   = !(mv_q && !m_axis_tready);
  assign s_sample_tready = !fifo_empty && advance;
  assign hs        = s_sample_tvalid && s_sample_tready;
  assign push_ok   = coef_push && (!fifo_full || hs);

  coef_fifo #(
    .DW    (COEF_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (coef_push),
    .wdata_i (coef_tdata),
    .pop_i   (hs),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

  // Credit loop, coefficient lag, frame index, flags.
  always_comb begin
    lag_d = (lag_q << 1) | COEF_DATA_LAG'(coef_tvalid);
    inf_d = inf_q + CNT_W'(en_q);
    if (coef_push && inf_d != '0)
      inf_d = inf_d - CNT_W'(1);
    occ_nxt = {1'b0, fifo_cnt}
            + (CNT_W+1)'(push_ok)
            - (CNT_W+1)'(hs);
    en_d = (occ_nxt + {1'b0, inf_d})
         < (CNT_W+1)'(FIFO_DEPTH);
    ovf_d = ovf_q || (coef_push && fifo_full && !hs);
    fd_d  = mv_q && m_axis_tready && ml_q;
    idx_d = idx_q;
    if (hs)
      idx_d = (idx_q == IDX_W'(N_SAMPLES - 1))
            ? '0 : idx_q + IDX_W'(1);
  end

  // Two-stage multiply then round/saturate pipeline.
  always_comb begin
    s1_d = s1_q;
    mv_d = mv_q;
    ml_d = ml_q;
    md_d = md_q;
    rnd  = ($signed(s1_q.prod) + ROUND_C) >>> COEF_W;
    if (advance) begin
      s1_d.vld  = hs;
      s1_d.last = hs && (idx_q == IDX_W'(N_SAMPLES - 1));
      s1_d.prod = PROD_W'($signed(s_sample_tdata))
                * PROD_W'($signed({1'b0, fifo_rdata}));
      mv_d = s1_q.vld;
      ml_d = s1_q.last;
      md_d = sat_signed(rnd);
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lag_q <= '0;
      inf_q <= '0;
      idx_q <= '0;
      en_q  <= 1'b0;
      ovf_q <= 1'b0;
      fd_q  <= 1'b0;
      s1_q  <= '0;
      mv_q  <= 1'b0;
      ml_q  <= 1'b0;
      md_q  <= '0;
    end else begin
      lag_q <= lag_d;
      inf_q <= inf_d;
      idx_q <= idx_d;
      en_q  <= en_d;
      ovf_q <= ovf_d;
      fd_q  <= fd_d;
      s1_q  <= s1_d;
      mv_q  <= mv_d;
      ml_q  <= ml_d;
      md_q  <= md_d;
    end
  end

  assign coef_enable   = en_q;
  assign m_axis_tvalid = mv_q;
  assign m_axis_tdata  = md_q;
  assign m_axis_tlast  = ml_q;
  assign frame_done    = fd_q;
  assign coef_overflow = ovf_q;

endmodule

// File: tb/tb_hann_window_apply.sv
// tb_hann_window_apply: directed vectors and stream
// scenarios for the Hann window stage.
module tb_hann_window_apply;
  import fmcw_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        s_sample_tvalid = 1'b0;
  logic        s_sample_tready;
  logic [15:0] s_sample_tdata = '0;
  logic        coef_enable;
  logic        coef_tvalid;
  logic [15:0] coef_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b1;
  logic [15:0] m_axis_tdata;
  logic        m_axis_tlast;
  logic        frame_done;
  logic        coef_overflow;

  always #5 clk = ~clk;

  hann_window_apply dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .s_sample_tvalid (s_sample_tvalid),
    .s_sample_tready (s_sample_tready),
    .s_sample_tdata  (s_sample_tdata),
    .coef_enable     (coef_enable),
    .coef_tvalid     (coef_tvalid),
    .coef_tdata      (coef_tdata),
    .m_axis_tvalid   (m_axis_tvalid),
    .m_axis_tready   (m_axis_tready),
    .m_axis_tdata    (m_axis_tdata),
    .m_axis_tlast    (m_axis_tlast),
    .frame_done      (frame_done),
    .coef_overflow   (coef_overflow)
  );

  int checks = 0;
  int passed = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h",
                  nm, act, exp);
  endtask

  // Hann ROM reader stub: latency 3, data one cycle after valid.
  logic [15:0] rom [N_SAMPLES];
  logic        p0, p1, stub_vld;
  logic [15:0] stub_dat;
  int          stub_idx;
  logic        force_vld = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p0 <= 0; p1 <= 0; stub_vld <= 0;
      stub_dat <= '0; stub_idx <= 0;
    end else begin
      p0 <= coef_enable;
      p1 <= p0;
      stub_vld <= p1;
      if (stub_vld) begin
        stub_dat <= rom[stub_idx];
        stub_idx <= (stub_idx == N_SAMPLES-1) ? 0 : stub_idx + 1;
      end
    end
  end
  assign coef_tvalid = stub_vld | force_vld;
  assign coef_tdata  = stub_dat;

  function automatic logic [15:0] model(input logic [15:0] s,
                                        input logic [15:0] c);
    longint p;
    p = longint'($signed(s)) * longint'({1'b0, c});
    p = (p + 64'sd32768) >>> 16;
    if (p > 32767) p = 32767;
    if (p < -32768) p = -32768;
    return p[15:0];
  endfunction

  typedef struct {
    logic [15:0] y;
    logic        last;
    int          cyc;
  } exp_t;

  typedef struct {
    logic [15:0] s;
    logic [15:0] c;
    logic [15:0] y;
  } vec_t;

  exp_t        exp_q [$];
  logic [15:0] cap [$];
  logic [15:0] samp [1024];
  int  n_send = 0, ptr = 0, mdl_idx = 0, cyc = 0;
  int  out_beats = 0, first_last = 0, fd_cnt = 0;
  bit  drv_en = 0, rnd_mode = 0, lat_chk = 0;
  bit  stall_prev = 0;
  logic [15:0] held_d;
  logic        held_l;

  always @(posedge clk) cyc <= cyc + 1;

  // Downstream ready, output monitor and sample driver.
  always @(negedge clk) begin
    exp_t e;
    m_axis_tready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    #1;
    if (!rst_n) stall_prev = 0;
    else begin
      if (stall_prev) begin
        chk("stall_valid", m_axis_tvalid, 1);
        chk("stall_data", {held_l, held_d},
            {m_axis_tlast, m_axis_tdata});
      end
      if (m_axis_tvalid && !m_axis_tready)
        chk("stall_sready", s_sample_tready, 0);
      if (m_axis_tvalid && m_axis_tready) begin
        out_beats++;
        cap.push_back(m_axis_tdata);
        if (m_axis_tlast && first_last == 0)
          first_last = out_beats;
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL spurious_out: got %h expected none",
                   m_axis_tdata);
        end else begin
          e = exp_q.pop_front();
          chk("out_data", m_axis_tdata, e.y);
          chk("out_last", m_axis_tlast, e.last);
          if (lat_chk) chk("latency", cyc - e.cyc, 2);
        end
      end
      if (frame_done) fd_cnt++;
      stall_prev = m_axis_tvalid && !m_axis_tready;
      held_d = m_axis_tdata;
      held_l = m_axis_tlast;
    end
    if (drv_en && ptr < n_send) begin
      s_sample_tvalid = 1'b1;
      s_sample_tdata  = samp[ptr];
      if (s_sample_tready) begin
        exp_q.push_back('{y: model(samp[ptr], rom[mdl_idx]),
                          last: mdl_idx == N_SAMPLES-1,
                          cyc: cyc});
        mdl_idx = (mdl_idx + 1) % N_SAMPLES;
        ptr++;
      end
    end else s_sample_tvalid = 1'b0;
  end

  task automatic enter_reset();
    @(posedge clk); #2;
    rst_n = 0;
    drv_en = 0;
    s_sample_tvalid = 0;
    exp_q.delete();
    cap.delete();
    mdl_idx = 0; ptr = 0; n_send = 0;
    out_beats = 0; first_last = 0; fd_cnt = 0;
  endtask

  task automatic leave_reset();
    repeat (3) @(posedge clk);
    #2 rst_n = 1;
  endtask

  task automatic run_until_done(input int budget,
                                input string nm);
    int i = 0;
    while (!(ptr == n_send && exp_q.size() == 0) && i < budget) begin
      @(posedge clk);
      i++;
    end
    chk(nm, (ptr == n_send && exp_q.size() == 0), 1);
    repeat (4) @(posedge clk);
  endtask

  vec_t vec [5];

  initial begin
    int cnt, first, i;
    for (int k = 0; k < N_SAMPLES; k++)
      rom[k] = 16'(k * 517 + 1000);
    vec[0] = '{16'h4000, 16'h8000, 16'h2000};
    vec[1] = '{16'h7FFF, 16'hFFFF, 16'h7FFF};
    vec[2] = '{16'h8000, 16'hFFFF, 16'h8001};
    vec[3] = '{16'h0001, 16'h8000, 16'h0001};
    vec[4] = '{16'hFFFF, 16'h8000, 16'h0000};

    // Reset state.
    #1 rst_n = 0;
    #1 chk("rst_out", {coef_enable, s_sample_tready, m_axis_tvalid,
                       m_axis_tdata, m_axis_tlast, frame_done,
                       coef_overflow}, 0);

    // Credit fill with no samples.
    leave_reset();
    @(negedge clk);
    chk("en_pre", coef_enable, 0);
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); @(negedge clk);
      if (k == 0) chk("en_first", coef_enable, 1);
      if (coef_enable) cnt++;
    end
    chk("en_count", cnt, 4);
    chk("fifo_full", dut.u_fifo.count_o, 4);
    chk("ovf_clear", coef_overflow, 0);

    // Forced coefficient into a full FIFO.
    @(posedge clk); #2 force_vld = 1;
    @(posedge clk); #2 force_vld = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("ovf_set", coef_overflow, 1);
    chk("ovf_dropped", dut.u_fifo.count_o, 4);
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("ovf_sticky", coef_overflow, 1);

    // Arithmetic vectors.
    enter_reset();
    for (int k = 0; k < 5; k++) begin
      rom[k]  = vec[k].c;
      samp[k] = vec[k].s;
    end
    n_send = 5;
    leave_reset();
    drv_en = 1;
    run_until_done(200, "arith_done");
    chk("arith_cnt", cap.size(), 5);
    for (int k = 0; k < 5; k++)
      if (k < cap.size())
        chk($sformatf("arith[%0d]", k), cap[k], vec[k].y);
    for (int k = 0; k < 5; k++)
      rom[k] = 16'(k * 517 + 1000);

    // Starvation then two full frames.
    enter_reset();
    for (int k = 0; k < 256; k++) samp[k] = 16'($urandom);
    samp[0] = 16'h7FFF;
    samp[1] = 16'h8000;
    n_send = 256;
    lat_chk = 1;
    drv_en = 1;
    leave_reset();
    first = 0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); @(negedge clk);
      if (s_sample_tready && first == 0) first = k;
    end
    chk("starve_ready", first, 6);
    run_until_done(3000, "frames_done");
    chk("frames_beats", out_beats, 256);
    chk("frames_fd", fd_cnt, 2);
    chk("frames_ovf", coef_overflow, 0);
    lat_chk = 0;

    // Random backpressure over three frames.
    enter_reset();
    for (int k = 0; k < 384; k++) samp[k] = 16'($urandom);
    n_send = 384;
    rnd_mode = 1;
    leave_reset();
    drv_en = 1;
    run_until_done(8000, "bp_done");
    chk("bp_beats", out_beats, 384);
    chk("bp_fd", fd_cnt, 3);
    rnd_mode = 0;

    // Reset in the middle of a frame.
    enter_reset();
    for (int k = 0; k < 300; k++) samp[k] = 16'($urandom);
    n_send = 300;
    leave_reset();
    drv_en = 1;
    i = 0;
    while (ptr < 60 && i < 1000) begin
      @(posedge clk);
      i++;
    end
    chk("mid_reach60", ptr >= 60, 1);
    enter_reset();
    @(negedge clk);
    chk("mid_rst_out", {coef_enable, s_sample_tready, m_axis_tvalid,
                        m_axis_tdata, m_axis_tlast, frame_done}, 0);
    n_send = 130;
    leave_reset();
    drv_en = 1;
    run_until_done(2000, "mid_done");
    chk("mid_first_last", first_last, 128);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
